// File: rtl/slc3_datapath_gen.sv
// SLC-3 datapath generalised to WIDTH bits: PC/IR/MAR/MDR, 8-entry register
// file, ALU, address adder, NZP/BEN, and one shared bus. MDR memory reads
// use a waited handshake with timeout, and bus contention is counted.
//
// Memory read handshake: a read is requested by LD_MDR=1 with MIO_EN=1 while
// idle; data is accepted on the first rising edge where mem_ready=1. While
// mdr_busy=1 the controller must hold its state and further LD_MDR is ignored.
module slc3_datapath_gen #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] PC_RESET    = '0,
  parameter int               MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LD_REG,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_IR,
  input  logic             LD_PC,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GatePC,
  input  logic             GateMARMUX,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             SR2MUX,
  input  logic             ADDR1MUX,
  input  logic             MIO_EN,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       ALUK,
  input  logic [1:0]       PCMUX,
  input  logic [WIDTH-1:0] MDR_In,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic             BEN,
  output logic             mdr_busy,
  output logic             mem_err,
  output logic             bus_err,
  output logic [7:0]       conflict_cnt,
  output logic             dbg_mdr_state
);

  // Wait counter must hold values 1..MEM_TIMEOUT.
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} mdr_state_t;

  mdr_state_t       state, next_state;
  logic [CW-1:0]    wait_cnt;
  logic             mdr_ld_bus, mdr_ld_mem, err_set;

  logic [WIDTH-1:0] regs [8];
  logic [2:0]       nzp;
  logic [2:0]       dr, sr1, sr2;
  logic [WIDTH-1:0] sext5, sext6, sext9, sext11;
  logic [WIDTH-1:0] sr1_val, alu_b, alu_out;
  logic [WIDTH-1:0] addr1, addr2, adder_out;
  logic [WIDTH-1:0] bus, pc_next;
  logic [2:0]       gate_cnt;

  assign sext5  = {{(WIDTH-5){IR[4]}},   IR[4:0]};
  assign sext6  = {{(WIDTH-6){IR[5]}},   IR[5:0]};
  assign sext9  = {{(WIDTH-9){IR[8]}},   IR[8:0]};
  assign sext11 = {{(WIDTH-11){IR[10]}}, IR[10:0]};

  assign dr  = DRMUX  ? 3'b111   : IR[11:9];
  assign sr1 = SR1MUX ? IR[8:6]  : IR[11:9];
  assign sr2 = IR[2:0];

  assign sr1_val = regs[sr1];
  assign alu_b   = SR2MUX ? sext5 : regs[sr2];

  // ALU operation select
  always_comb begin
    alu_out = sr1_val;
    case (ALUK)
      2'b00:   alu_out = sr1_val + alu_b;
      2'b01:   alu_out = sr1_val & alu_b;
      2'b10:   alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
  end

  // Address adder operand selection
  always_comb begin
    addr1 = ADDR1MUX ? sr1_val : PC;
    addr2 = '0;
    case (ADDR2MUX)
      2'b00:   addr2 = '0;
      2'b01:   addr2 = sext6;
      2'b10:   addr2 = sext9;
      default: addr2 = sext11;
    endcase
    adder_out = addr1 + addr2;
  end

  // Prioritised bus driver; contention is flagged, not prevented
  always_comb begin
    if (GateMDR)         bus = MDR;
    else if (GateALU)    bus = alu_out;
    else if (GatePC)     bus = PC;
    else if (GateMARMUX) bus = adder_out;
    else                 bus = '0;
    gate_cnt = 3'(GateMDR) + 3'(GateALU) + 3'(GatePC) + 3'(GateMARMUX);
    bus_err  = (gate_cnt >= 3'd2);
  end

  // Next PC selection
  always_comb begin
    pc_next = PC;
    case (PCMUX)
      2'b00:   pc_next = PC + 1'b1;
      2'b01:   pc_next = bus;
      2'b10:   pc_next = adder_out;
      default: pc_next = PC;
    endcase
  end

  // Register file write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (LD_REG) begin
      regs[dr] <= bus;
    end
  end

  // PC, IR, MAR, condition codes and branch enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC  <= PC_RESET;
      IR  <= '0;
      MAR <= '0;
      nzp <= 3'b010;
      BEN <= 1'b0;
    end else begin
      if (LD_PC)  PC  <= pc_next;
      if (LD_IR)  IR  <= bus;
      if (LD_MAR) MAR <= bus;
      if (LD_CC)  nzp <= bus[WIDTH-1] ? 3'b100 : ((bus == '0) ? 3'b010 : 3'b001);
      // BEN samples the NZP value held before this edge
      if (LD_BEN) BEN <= (IR[11] & nzp[2]) | (IR[10] & nzp[1]) | (IR[9] & nzp[0]);
    end
  end

  // MDR read FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // MDR read FSM: next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (LD_MDR && MIO_EN && !mem_ready) next_state = S_WAIT;
      S_WAIT: if (mem_ready || (wait_cnt == TIMEOUT_VAL)) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // MDR read FSM: outputs and load strobes
  always_comb begin
    mdr_busy      = (state == S_WAIT);
    dbg_mdr_state = state;
    mdr_ld_bus    = (state == S_IDLE) && LD_MDR && !MIO_EN;
    mdr_ld_mem    = ((state == S_IDLE) && LD_MDR && MIO_EN && mem_ready) ||
                    ((state == S_WAIT) && mem_ready);
    err_set       = (state == S_WAIT) && !mem_ready && (wait_cnt == TIMEOUT_VAL);
  end

  // MDR, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MDR      <= '0;
      wait_cnt <= CW'(1);
      mem_err  <= 1'b0;
    end else begin
      if (mdr_ld_mem)      MDR <= MDR_In;
      else if (mdr_ld_bus) MDR <= bus;
      // Preloaded to 1 so the first WAIT cycle counts as one
      if (state == S_IDLE) wait_cnt <= CW'(1);
      else if (!mem_ready) wait_cnt <= wait_cnt + 1'b1;
      if (err_set) mem_err <= 1'b1;
    end
  end

  // Saturating bus-contention counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              conflict_cnt <= 8'd0;
    else if (bus_err && conflict_cnt != 8'hFF) conflict_cnt <= conflict_cnt + 8'd1;
  end

endmodule

// File: tb/tb_slc3_datapath_gen.sv
// Bench for slc3_datapath_gen: a 16-bit instance (PC_RESET=3000, timeout 4)
// checked against an architectural model, plus a 32-bit instance sharing
// the controls for the wide-arithmetic regression.
module tb_slc3_datapath_gen;

  logic clk = 1'b0;
  logic reset;
  logic LD_REG, LD_BEN, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR;
  logic GateMDR, GateALU, GatePC, GateMARMUX;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [1:0] ADDR2MUX, ALUK, PCMUX;
  logic mem_ready;
  logic [15:0] mdr_in16;
  logic [31:0] mdr_in32;

  logic [15:0] ir16, pc16, mar16, mdr16;
  logic        ben16, busy16, err16, berr16, st16;
  logic [7:0]  cnt16;
  logic [31:0] ir32, pc32, mar32, mdr32;
  logic        ben32, busy32, err32, berr32, st32;
  logic [7:0]  cnt32;

  // Architectural model of the 16-bit instance
  logic [15:0] m_reg [8];
  logic [15:0] m_pc, m_ir, m_mar, m_mdr;
  logic [2:0]  m_nzp;
  logic        m_ben;
  int n_cmp = 0;
  int n_fail = 0;

  slc3_datapath_gen #(.WIDTH(16), .PC_RESET(16'h3000), .MEM_TIMEOUT(4)) u_dut (
    .clk(clk), .reset(reset),
    .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_IR(LD_IR), .LD_PC(LD_PC),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .GateMDR(GateMDR), .GateALU(GateALU), .GatePC(GatePC), .GateMARMUX(GateMARMUX),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .PCMUX(PCMUX),
    .MDR_In(mdr_in16), .mem_ready(mem_ready),
    .IR(ir16), .PC(pc16), .MAR(mar16), .MDR(mdr16), .BEN(ben16),
    .mdr_busy(busy16), .mem_err(err16), .bus_err(berr16), .conflict_cnt(cnt16),
    .dbg_mdr_state(st16)
  );

  slc3_datapath_gen #(.WIDTH(32), .PC_RESET(32'h0), .MEM_TIMEOUT(15)) u_dut32 (
    .clk(clk), .reset(reset),
    .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_IR(LD_IR), .LD_PC(LD_PC),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .GateMDR(GateMDR), .GateALU(GateALU), .GatePC(GatePC), .GateMARMUX(GateMARMUX),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .PCMUX(PCMUX),
    .MDR_In(mdr_in32), .mem_ready(mem_ready),
    .IR(ir32), .PC(pc32), .MAR(mar32), .MDR(mdr32), .BEN(ben32),
    .mdr_busy(busy32), .mem_err(err32), .bus_err(berr32), .conflict_cnt(cnt32),
    .dbg_mdr_state(st32)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic signed [15:0] t;
    t = $signed(v << (16 - bits));
    return 16'(t >>> (16 - bits));
  endfunction

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v[15])        return 3'b100;
    else if (v == 0)  return 3'b010;
    else              return 3'b001;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    LD_REG = 0; LD_BEN = 0; LD_CC = 0; LD_IR = 0; LD_PC = 0; LD_MAR = 0; LD_MDR = 0;
    GateMDR = 0; GateALU = 0; GatePC = 0; GateMARMUX = 0;
    DRMUX = 0; SR1MUX = 0; SR2MUX = 0; ADDR1MUX = 0; MIO_EN = 0;
    ADDR2MUX = 2'b00; ALUK = 2'b00; PCMUX = 2'b11; mem_ready = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
    m_pc = 16'h3000; m_ir = 0; m_mar = 0; m_mdr = 0; m_nzp = 3'b010; m_ben = 0;
  endtask

  // Zero-wait memory read into MDR
  task automatic mem_read(input logic [15:0] v, input logic [31:0] v32);
    clr(); MIO_EN = 1; LD_MDR = 1; mem_ready = 1; mdr_in16 = v; mdr_in32 = v32;
    tick(); clr(); m_mdr = v;
  endtask

  task automatic load_ir(input logic [15:0] v, input logic [31:0] v32);
    mem_read(v, v32); GateMDR = 1; LD_IR = 1; tick(); clr(); m_ir = v;
  endtask

  task automatic write_reg(input logic [2:0] r, input logic [15:0] v, input logic [31:0] v32);
    load_ir({4'b0, r, 9'b0}, {20'b0, r, 9'b0});
    mem_read(v, v32); GateMDR = 1; LD_REG = 1; tick(); clr(); m_reg[r] = v;
  endtask

  // Observe R[r] by passing it through the ALU into MAR
  task automatic read_reg(input logic [2:0] r, input string tag);
    load_ir({4'b0, r, 9'b0}, {20'b0, r, 9'b0});
    SR1MUX = 0; ALUK = 2'b11; GateALU = 1; LD_MAR = 1; tick(); clr();
    m_mar = m_reg[r];
    chk(tag, mar16, m_mar);
  endtask

  initial begin
    logic [2:0]  ra, rb, rd, mask;
    logic [4:0]  imm;
    logic [15:0] va, vb, res, a, b, ir;
    int          op;
    logic [15:0] v;

    clr(); mdr_in16 = 0; mdr_in32 = 0;
    reset = 0; model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc16, m_pc);
    chk("rst_ir", ir16, 16'h0);
    chk("rst_mar", mar16, 16'h0);
    chk("rst_mdr", mdr16, 16'h0);
    chk("rst_busy", busy16, 1'b0);
    chk("rst_err", err16, 1'b0);
    chk("rst_cnt", cnt16, 8'd0);
    chk("rst_ben", ben16, 1'b0);
    chk("rst_bus_err", berr16, 1'b0);
    chk("rst_pc32", pc32, 32'h0);
    reset = 1; tick();

    // PC paths
    LD_PC = 1; PCMUX = 2'b01; tick(); clr(); m_pc = 16'h0;
    chk("pc_bus_nogate", pc16, m_pc);
    mem_read(16'hFFFF, 32'hFFFF);
    GateMDR = 1; LD_PC = 1; PCMUX = 2'b01; tick(); clr(); m_pc = 16'hFFFF;
    chk("pc_from_bus", pc16, m_pc);
    GatePC = 1; LD_MAR = 1; LD_PC = 1; PCMUX = 2'b00; tick(); clr();
    m_mar = m_pc; m_pc = m_pc + 16'd1;
    chk("mar_from_pc", mar16, m_mar);
    chk("pc_wrap", pc16, 16'h0000);
    load_ir(16'h01F0, 32'h01F0);
    GateMARMUX = 1; LD_MAR = 1; ADDR1MUX = 0; ADDR2MUX = 2'b10; LD_PC = 1; PCMUX = 2'b10;
    tick(); clr();
    m_mar = m_pc + sx(m_ir, 9); m_pc = m_mar;
    chk("adder_pc_sext9", mar16, m_mar);
    chk("pc_from_adder", pc16, m_pc);

    // Branch enable against NZP
    load_ir(16'h0400, 32'h0400);
    LD_BEN = 1; tick(); clr(); m_ben = |(m_ir[11:9] & m_nzp);
    chk("ben_brz_reset_nzp", ben16, m_ben);
    mem_read(16'h8000, 32'h8000);
    GateMDR = 1; LD_CC = 1; tick(); clr(); m_nzp = cc_of(16'h8000);
    LD_BEN = 1; tick(); clr(); m_ben = |(m_ir[11:9] & m_nzp);
    chk("ben_brz_neg", ben16, m_ben);
    mem_read(16'h0000, 32'h0);
    GateMDR = 1; LD_CC = 1; LD_BEN = 1; tick(); clr();
    m_ben = |(m_ir[11:9] & m_nzp); m_nzp = cc_of(16'h0000);
    chk("ben_same_cycle_old_nzp", ben16, m_ben);
    LD_BEN = 1; tick(); clr(); m_ben = |(m_ir[11:9] & m_nzp);
    chk("ben_after_cc", ben16, m_ben);

    // ADD R2,R1,#-3 (16-bit) and ADD R2,R1,#1 on 7FFFFFFF (32-bit)
    write_reg(3'd1, 16'd5, 32'h7FFF_FFFF);
    load_ir(16'h147D, 32'h1461);
    SR1MUX = 1; SR2MUX = 1; ALUK = 2'b00; GateALU = 1; LD_REG = 1; LD_CC = 1;
    tick(); clr();
    m_reg[2] = m_reg[1] + sx(16'h147D, 5); m_nzp = cc_of(m_reg[2]);
    read_reg(3'd2, "add_imm_r2");
    chk("add32_r2", mar32, 32'h8000_0000);
    load_ir(16'h0200, 32'h0800);
    LD_BEN = 1; tick(); clr(); m_ben = |(m_ir[11:9] & m_nzp);
    chk("ben_brp_after_add", ben16, m_ben);
    chk("ben32_brn_after_add", ben32, 1'b1);

    // Address adder with register base, SEXT11 and SEXT6
    load_ir(16'h0441, 32'h0441);
    SR1MUX = 1; ADDR1MUX = 1; ADDR2MUX = 2'b11; GateMARMUX = 1; LD_MAR = 1; tick(); clr();
    m_mar = m_reg[m_ir[8:6]] + sx(m_ir, 11);
    chk("adder_reg_sext11", mar16, m_mar);
    SR1MUX = 1; ADDR1MUX = 1; ADDR2MUX = 2'b01; GateMARMUX = 1; LD_MAR = 1; tick(); clr();
    m_mar = m_reg[m_ir[8:6]] + sx(m_ir, 6);
    chk("adder_reg_sext6", mar16, m_mar);

    // Randomised ALU operations against the model
    for (int it = 0; it < 16; it++) begin
      ra = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7));
      rd = 3'($urandom_range(0, 7)); mask = 3'($urandom_range(1, 7));
      va = 16'($urandom_range(0, 65535)); vb = 16'($urandom_range(0, 65535));
      imm = 5'($urandom_range(0, 31)); op = $urandom_range(0, 4);
      write_reg(ra, va, {16'h0, va});
      write_reg(rb, vb, {16'h0, vb});
      a = m_reg[ra]; b = m_reg[rb];
      case (op)
        0: begin ir = {4'b0001, rd, ra, 3'b000, rb}; res = a + b; end
        1: begin ir = {4'b0001, rd, ra, 1'b1, imm};  res = a + sx({11'b0, imm}, 5); end
        2: begin ir = {4'b0101, rd, ra, 3'b000, rb}; res = a & b; end
        3: begin ir = {4'b0101, rd, ra, 1'b1, imm};  res = a & sx({11'b0, imm}, 5); end
        default: begin ir = {4'b1001, rd, ra, 6'b111111}; res = ~a; end
      endcase
      load_ir(ir, {16'h0, ir});
      SR1MUX = 1; SR2MUX = ir[5]; GateALU = 1; LD_REG = 1; LD_CC = 1;
      ALUK = (op < 2) ? 2'b00 : ((op < 4) ? 2'b01 : 2'b10);
      tick(); clr();
      m_reg[rd] = res; m_nzp = cc_of(res);
      read_reg(rd, "rand_alu_result");
      load_ir({4'b0, mask, 9'b0}, {20'b0, mask, 9'b0});
      LD_BEN = 1; tick(); clr(); m_ben = |(mask & m_nzp);
      chk("rand_ben", ben16, m_ben);
    end

    // Waited read: three not-ready edges, data on the fourth; LD_MDR held high
    clr(); MIO_EN = 1; LD_MDR = 1; mem_ready = 0; mdr_in16 = 16'hABCD; mdr_in32 = 32'hABCD;
    tick();
    chk("wait_busy_1", busy16, 1'b1);
    chk("wait_state_dbg", st16, 1'b1);
    tick();
    chk("wait_busy_2", busy16, 1'b1);
    tick();
    chk("wait_busy_3", busy16, 1'b1);
    chk("wait_mdr_held", mdr16, m_mdr);
    mem_ready = 1; tick(); clr(); m_mdr = 16'hABCD;
    chk("wait_mdr_data", mdr16, m_mdr);
    chk("wait_busy_done", busy16, 1'b0);
    chk("wait_no_err", err16, 1'b0);

    // Timeout after four WAIT cycles
    clr(); MIO_EN = 1; LD_MDR = 1; mem_ready = 0; mdr_in16 = 16'h1234;
    tick(); LD_MDR = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_busy", busy16, 1'b1);
      chk("to_err_early", err16, 1'b0);
    end
    tick(); clr();
    chk("to_busy_end", busy16, 1'b0);
    chk("to_err_set", err16, 1'b1);
    chk("to_mdr_unchanged", mdr16, m_mdr);
    mem_read(16'h5555, 32'h5555);
    chk("to_err_sticky", err16, 1'b1);
    chk("to_next_read", mdr16, m_mdr);

    // Reset during WAIT aborts the read
    clr(); MIO_EN = 1; LD_MDR = 1; mem_ready = 0; mdr_in16 = 16'h7777;
    tick(); clr();
    chk("rw_busy", busy16, 1'b1);
    reset = 0; #2;
    model_reset();
    chk("rw_busy_cleared", busy16, 1'b0);
    chk("rw_err_cleared", err16, 1'b0);
    chk("rw_mdr", mdr16, m_mdr);
    @(posedge clk); #1; reset = 1; tick();

    // Bus contention: ALU and PC together for 300 cycles
    v = 16'($urandom_range(1, 65535));
    write_reg(3'd4, v, {16'h0, v});
    load_ir(16'h0800, 32'h0800);
    SR1MUX = 0; ALUK = 2'b11; GateALU = 1; GatePC = 1; LD_MAR = 1; #1;
    chk("conflict_bus_err", berr16, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 10) chk("conflict_cnt_10", cnt16, 8'(i));
    end
    m_mar = m_reg[4];
    chk("conflict_bus_alu", mar16, m_mar);
    chk("conflict_cnt_sat", cnt16, 8'd255);
    clr(); #1;
    chk("conflict_clear_bus_err", berr16, 1'b0);
    tick();
    chk("conflict_cnt_hold", cnt16, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/slc3_datapath_gen.md
# slc3_datapath_gen

Parametrised SLC-3 datapath: PC, IR, MAR, MDR, 8-entry register file, ALU, address adder, NZP condition codes and BEN, joined by one internal bus driven under controller gate signals. Generalises the 16-bit datapath to any WIDTH ≥ 16. Adds a waited memory-read handshake on MDR with timeout, bus-contention detection with a saturating conflict counter, and a configurable PC reset vector. Sits between the ISDU controller and the memory/IO subsystem.

## Interface
- WIDTH, 16, datapath/bus width (≥16); all immediates sign-extended to WIDTH
- PC_RESET, 0, PC value on reset (WIDTH bits)
- MEM_TIMEOUT, 15, max WAIT cycles before memory error (≥1)
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low; all state cleared while 0
- LD_REG, LD_BEN, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR  in  1 each  register load enables
- GateMDR, GateALU, GatePC, GateMARMUX  in  1 each  bus drive enables
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN  in  1 each  mux selects
- ADDR2MUX, ALUK, PCMUX  in  2 each  mux/op selects
- MDR_In  in  WIDTH  memory read data
- mem_ready  in  1  memory read data valid
- IR, PC, MAR, MDR  out  WIDTH  register contents
- BEN  out  1  branch enable
- mdr_busy  out  1  memory read pending; controller must hold state
- mem_err  out  1  sticky: memory read timed out
- bus_err  out  1  combinational: >1 gate asserted this cycle
- conflict_cnt  out  8  saturating count of cycles with bus_err=1

## Operation
- Bus: priority GateMDR > GateALU > GatePC > GateMARMUX; none asserted → 0. bus_err=1 when ≥2 gates high.
- Sign extension: SEXT5=IR[4:0], SEXT6=IR[5:0], SEXT9=IR[8:0], SEXT11=IR[10:0], each to WIDTH.
- DR = DRMUX ? 3'b111 : IR[11:9]; SR1 = SR1MUX ? IR[8:6] : IR[11:9]; SR2 = IR[2:0].
- ALU A = R[SR1]; B = SR2MUX ? SEXT5 : R[SR2]. ALUK: 00 A+B (mod 2^WIDTH), 01 A&B, 10 ~A, 11 A.
- Address adder = ADDR1 + ADDR2; ADDR1 = ADDR1MUX ? R[SR1] : PC; ADDR2MUX: 00 0, 01 SEXT6, 10 SEXT9, 11 SEXT11. MARMUX drives adder output.
- PCMUX: 00 PC+1 (wraps), 01 bus, 10 adder, 11 PC (hold).
- LD_REG writes bus into R[DR]; LD_IR, LD_MAR load bus; LD_CC: N=bus[WIDTH-1], Z=(bus==0), P=otherwise.
- LD_BEN: BEN ← (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), using current NZP.
- MDR, MIO_EN=0: LD_MDR loads bus at the edge.
- MDR, MIO_EN=1, FSM IDLE/WAIT:
  - IDLE, LD_MDR=1, mem_ready=1: MDR←MDR_In, stay IDLE.
  - IDLE, LD_MDR=1, mem_ready=0: → WAIT, counter=1.
  - WAIT: first edge with mem_ready=1 → MDR←MDR_In, → IDLE. Otherwise counter++; at counter=MEM_TIMEOUT with mem_ready=0 → IDLE, mem_err←1, MDR unchanged.
  - LD_MDR in WAIT ignored; no second request queued.
- mdr_busy = (state==WAIT).
- conflict_cnt increments on each edge with bus_err=1, saturates at 255.

## Timing
- All state updates on rising clk; outputs are register values (bus_err excepted).
- Reset (reset=0, asynchronous): PC=PC_RESET; IR=MAR=MDR=0; R0..R7=0; NZP=010; BEN=0; FSM IDLE; mdr_busy=0; mem_err=0; conflict_cnt=0. Reset mid-WAIT aborts the read, no MDR update.
- Register-file read is combinational. Same-cycle write and read of one register returns the old value; new value visible next cycle.
- LD_BEN with LD_CC in the same cycle uses pre-update NZP.
- LD_PC with PCMUX=01 and no gate loads 0.
- Zero-wait memory read: MDR valid 1 cycle after the LD_MDR edge. N-wait read: MDR valid at edge N+1.
- mem_err and conflict_cnt clear only on reset.

## Test plan
- Reset with PC_RESET=16'h3000 → PC=3000, IR/MAR/MDR=0, NZP=010, mdr_busy=0, conflict_cnt=0.
- GatePC+LD_MAR, PCMUX=00+LD_PC at PC=FFFF → MAR=FFFF, PC=0000. Then R1=5, IR=ADD R2,R1,#-3 (SR2MUX=1, ALUK=00), GateALU+LD_REG+LD_CC → R2=0002, NZP=001.
- IR=BRz, NZP=010, LD_BEN → BEN=1. NZP=100 → BEN=0. LD_CC and LD_BEN same cycle uses old NZP.
- MIO_EN=1, LD_MDR, mem_ready low 3 cycles then high with MDR_In=ABCD → mdr_busy high 3 cycles, MDR=ABCD at 4th edge, mem_err=0.
- MEM_TIMEOUT=4, mem_ready held 0 → mem_err=1 after 4 WAIT cycles, MDR unchanged. Reset mid-WAIT → IDLE, mem_err=0.
- GateALU+GatePC together for 300 cycles → bus_err=1, bus = ALU value, conflict_cnt saturates at 255. WIDTH=32 regression: ADD of 7FFFFFFF+1 → 80000000, N=1.
